alu_requester: RTL
==================

ALU_REQUESTER -- requirements
Module: alu_requester

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, command FIFO entries (power of 2, >=2).
REQ-002 SHALL have parameter TIMEOUT, default 16, maximum start-asserted cycles before abort (>=2).
REQ-003 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have ports cmd_valid input 1, cmd_ready output 1: command push handshake.
REQ-006 SHALL have ports cmd_a input 8, cmd_b input 8, cmd_op input alu_opcode_t: command payload.
REQ-007 SHALL have ports alu_a output 8, alu_b output 8, alu_op output alu_opcode_t, alu_start output 1: ALU request.
REQ-008 SHALL have ports alu_result input 16, alu_done input 1, alu_error input 1: ALU response.
REQ-009 SHALL have ports rsp_valid output 1, rsp_ready input 1: response handshake.
REQ-010 SHALL have ports rsp_result output 16, rsp_error output 1, rsp_timeout output 1, rsp_op output alu_opcode_t: response payload.

Function
REQ-011 SHALL push a command on any cycle with cmd_valid && cmd_ready; cmd_ready = FIFO not full.
REQ-012 SHALL use FSM states IDLE, ISSUE, RESP, GAP.
REQ-013 IDLE: FIFO not empty -> pop head into issue registers, go to ISSUE next cycle.
REQ-014 ISSUE: alu_start=1; alu_a/alu_b/alu_op driven from issue registers, stable for the whole ISSUE state.
REQ-015 ISSUE: alu_done=1 -> capture alu_result, alu_error into response registers, rsp_timeout=0, go to RESP.
REQ-016 ISSUE: cycle counter counts start-high cycles from 1; on cycle TIMEOUT with no alu_done -> rsp_result=0, rsp_error=0, rsp_timeout=1, go to RESP.
REQ-017 alu_done and timeout in the same cycle -> alu_done wins, rsp_timeout=0.
REQ-018 alu_done outside ISSUE SHALL be ignored (no capture, no state change).
REQ-019 RESP: rsp_valid=1, payload stable until rsp_valid && rsp_ready; then go to GAP.
REQ-020 GAP: alu_start=0 for exactly one cycle, then IDLE; guarantees start low between consecutive requests.
REQ-021 alu_start SHALL be 0 in IDLE, RESP, GAP.
REQ-022 Minimum latency cmd push -> rsp_valid: 2 cycles + ALU done latency (IDLE pop, ISSUE cycles).
REQ-023 Push SHALL be accepted in any state, including same cycle as pop; simultaneous push+pop on full FIFO is not accepted (cmd_ready=0).
REQ-024 FIFO pointers SHALL wrap modulo FIFO_DEPTH; count range 0..FIFO_DEPTH.
REQ-025 rsp_op SHALL echo the opcode of the command that produced the response.

Reset
REQ-026 reset_n=0 SHALL set state IDLE, FIFO empty, counter 0, alu_start=0, rsp_valid=0, rsp_result=0, rsp_error=0, rsp_timeout=0, alu_a=0, alu_b=0.
REQ-027 cmd_ready SHALL read 0 during reset, 1 first cycle after release.
REQ-028 Reset mid-ISSUE or mid-RESP SHALL discard in-flight command, pending response and FIFO contents; no response emitted.

Structure
REQ-029 alu_opcode_t SHALL come from tinyalu_pkg; add alu_cmd_t (a, b, op packed struct) and req_state_t enum to tinyalu_pkg.
REQ-030 Command FIFO SHALL be sub-module alu_cmd_fifo (parameter DEPTH, alu_cmd_t entries, full/empty flags).
REQ-031 Response path SHALL be a single register set, no response FIFO.

Verification
REQ-032 Push add a=8'h0F b=8'h01, ALU model done 1 cycle after start -> rsp_result=16'h0010, error=0, timeout=0.
REQ-033 Push mul a=8'hFF b=8'hFF, done 3 cycles after start -> rsp_result=16'hFE01; alu_start high exactly 3 cycles then low >=1 cycle.
REQ-034 Push reserved opcode, model returns done+error same cycle -> rsp_error=1, rsp_op equals pushed opcode.
REQ-035 Model never asserts done -> alu_start high exactly 16 cycles, rsp_timeout=1, rsp_result=16'h0000.
REQ-036 rsp_ready held 0, push 6 commands back-to-back -> cmd_ready drops after 5th accepted (1 in flight + 4 queued); release rsp_ready -> 6 responses in push order.
REQ-037 Assert reset_n=0 for 1 cycle during ISSUE -> no rsp_valid afterwards, cmd_ready=1, alu_start=0.

Source files
------------

// File: rtl/tinyalu_pkg.sv
// Shared types for the tiny ALU: opcodes, the queued command record and
// the requester FSM states.
package tinyalu_pkg;

    // Encodings 5..7 are reserved; the ALU flags them with alu_error.
    typedef enum logic [2:0] {
        OP_NOP = 3'd0,
        OP_ADD = 3'd1,
        OP_AND = 3'd2,
        OP_XOR = 3'd3,
        OP_MUL = 3'd4
    } alu_opcode_t;

    typedef struct packed {
        logic [7:0]  a;
        logic [7:0]  b;
        alu_opcode_t op;
    } alu_cmd_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2,
        GAP   = 2'd3
    } req_state_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command queue in front of the requester: power-of-two depth, pointers wrap
// naturally, occupancy count drives the full/empty flags.
module alu_cmd_fifo
    import tinyalu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     reset_n,
    input  logic     push,
    input  alu_cmd_t push_data,
    input  logic     pop,
    output alu_cmd_t pop_data,
    output logic     full,
    output logic     empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    alu_cmd_t           mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W:0]     count;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Callers only push when not full and only pop when not empty.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign pop_data = mem[rd_ptr];
    assign full     = (count == (PTR_W+1)'(DEPTH));
    assign empty    = (count == '0);

endmodule

// File: rtl/alu_requester.sv
// Queues ALU commands, issues them one at a time with a bounded start pulse,
// and holds each response in a single register set until it is accepted.
module alu_requester
    import tinyalu_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_a,
    input  logic [7:0]  cmd_b,
    input  alu_opcode_t cmd_op,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output alu_opcode_t alu_op,
    output logic        alu_start,
    input  logic [15:0] alu_result,
    input  logic        alu_done,
    input  logic        alu_error,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_result,
    output logic        rsp_error,
    output logic        rsp_timeout,
    output alu_opcode_t rsp_op
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    req_state_t        state;
    req_state_t        next_state;
    alu_cmd_t          head;
    alu_cmd_t          issue_cmd;
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    logic              timeout_hit;
    logic [CNT_W-1:0]  cnt;

    assign cmd_ready   = reset_n && !full;
    assign push        = cmd_valid && cmd_ready;
    assign timeout_hit = (cnt == TIMEOUT_CNT) && !alu_done;

    alu_cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_data ('{a: cmd_a, b: cmd_b, op: cmd_op}),
        .pop       (pop),
        .pop_data  (head),
        .full      (full),
        .empty     (empty)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (!empty) next_state = ISSUE;
            ISSUE:   if (alu_done || timeout_hit) next_state = RESP;
            RESP:    if (rsp_ready) next_state = GAP;
            GAP:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        pop       = 1'b0;
        alu_start = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            IDLE:    pop = !empty;
            ISSUE:   alu_start = 1'b1;
            RESP:    rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // cnt holds the number of the current start-high cycle, so it loads 1 on pop.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            issue_cmd   <= '0;
            cnt         <= '0;
            rsp_result  <= '0;
            rsp_error   <= 1'b0;
            rsp_timeout <= 1'b0;
            rsp_op      <= OP_NOP;
        end else if (pop) begin
            issue_cmd <= head;
            cnt       <= CNT_W'(1);
        end else if (state == ISSUE) begin
            if (alu_done) begin
                rsp_result  <= alu_result;
                rsp_error   <= alu_error;
                rsp_timeout <= 1'b0;
                rsp_op      <= issue_cmd.op;
                cnt         <= '0;
            end else if (timeout_hit) begin
                rsp_result  <= '0;
                rsp_error   <= 1'b0;
                rsp_timeout <= 1'b1;
                rsp_op      <= issue_cmd.op;
                cnt         <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign alu_a  = issue_cmd.a;
    assign alu_b  = issue_cmd.b;
    assign alu_op = issue_cmd.op;

endmodule
